// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU operations,
// PC source selects and the controller state enumeration.
package multicycle_control_pkg;

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_MUL  = 7'd2;
  localparam logic [6:0] OP_LDB  = 7'd16;
  localparam logic [6:0] OP_LDW  = 7'd17;
  localparam logic [6:0] OP_STB  = 7'd18;
  localparam logic [6:0] OP_STW  = 7'd19;
  localparam logic [6:0] OP_BEQ  = 7'd48;
  localparam logic [6:0] OP_JUMP = 7'd49;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMADR,
    S_MEMRD,
    S_MEMWR,
    S_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  function automatic logic is_alu_op(input logic [6:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LDB) || (op == OP_LDW) || (op == OP_STB) || (op == OP_STW);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle processor controller: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, plus a retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        Link,
  output logic        MemReadB,
  output logic        MemReadW,
  output logic        MemWriteB,
  output logic        MemWriteW,
  output logic [3:0]  ALUControl,
  output logic [1:0]  PCSrc,
  output logic        illegal,
  output logic [15:0] instr_count
);

  state_t      state, next_state;
  logic        armed;     // low for the first edge after reset release
  logic        load_wb;   // current write-back came from a load
  logic [3:0]  alu_q;     // ALU operation captured in DECODE
  logic [15:0] count_q;
  logic        retire;

  assign instr_count = count_q;

  // Control state: FSM register, reset-release arming, load flag, counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_START;
      armed   <= 1'b0;
      load_wb <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      if (next_state == S_WB)
        load_wb <= (state == S_MEMRD);
      if (retire)
        count_q <= count_q + 16'd1;
    end
  end

  // Capture the ALU operation once in DECODE so EXEC/WB ignore later opcode changes
  always_ff @(posedge clk) begin
    if (state == S_DECODE)
      alu_q <= is_alu_op(opcode) ? opcode[3:0] : ALU_ADD;
  end

  // Next-state and output decode; every output defaults to 0
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    Link       = 1'b0;
    MemReadB   = 1'b0;
    MemReadW   = 1'b0;
    MemWriteB  = 1'b0;
    MemWriteW  = 1'b0;
    ALUControl = ALU_ADD;
    PCSrc      = PC_PLUS4;
    illegal    = 1'b0;
    case (state)
      // Hold one extra edge after reset release so FETCH lands on the second edge
      S_START: next_state = armed ? S_FETCH : S_START;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          PCSrc      = PC_PLUS4;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_alu_op(opcode))       next_state = S_EXEC;
        else if (is_mem_op(opcode))  next_state = S_MEMADR;
        else if (opcode == OP_BEQ)   next_state = S_BRANCH;
        else if (opcode == OP_JUMP)  next_state = S_JUMP;
        else begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUControl = alu_q;
        next_state = S_WB;
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = load_wb;
        ALUControl = alu_q;
        next_state = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrc     = 1'b1;
        next_state = ((opcode == OP_LDB) || (opcode == OP_LDW)) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        MemReadB = (opcode == OP_LDB);
        MemReadW = (opcode == OP_LDW);
        if (mem_ready) next_state = S_WB;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        MemWriteB = (opcode == OP_STB);
        MemWriteW = (opcode == OP_STW);
        if (mem_ready) next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUControl = ALU_SUB;
        PCSrc      = PC_BRANCH;
        PCWrite    = zero;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = PC_JUMP;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        Link       = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_START;
    endcase
  end

  assign retire = (next_state == S_FETCH) &&
                  ((state == S_WB) || (state == S_MEMWR) ||
                   (state == S_BRANCH) || (state == S_JUMP));

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: hand-computed output vectors per cycle.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, IRWrite, PCWrite, RegWrite, ALUSrc, MemtoReg, Link;
  logic        MemReadB, MemReadW, MemWriteB, MemWriteW;
  logic [3:0]  ALUControl;
  logic [1:0]  PCSrc;
  logic        illegal;
  logic [15:0] instr_count;
  logic [17:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .Link(Link),
    .MemReadB(MemReadB), .MemReadW(MemReadW), .MemWriteB(MemWriteB), .MemWriteW(MemWriteW),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .illegal(illegal), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {mem_req, IRWrite, PCWrite, RegWrite, ALUSrc, MemtoReg, Link,
                 MemReadB, MemReadW, MemWriteB, MemWriteW, ALUControl, PCSrc, illegal};

  // Expected output vector, fields in the same order as outs
  function automatic logic [17:0] ov(input logic req, ir, pcw, rw, asrc, m2r, lnk,
                                     rdb, rdw, wrb, wrw, input logic [3:0] alu,
                                     input logic [1:0] pcs, input logic ill);
    return {req, ir, pcw, rw, asrc, m2r, lnk, rdb, rdw, wrb, wrw, alu, pcs, ill};
  endfunction

  localparam logic [17:0] O_ZERO   = 18'd0;
  localparam logic [17:0] O_FWAIT  = 18'h20000;  // mem_req only
  localparam logic [17:0] O_FREADY = 18'h38000;  // mem_req, IRWrite, PCWrite, PCSrc=0

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One JUMP instruction starting in FETCH; ends back in FETCH
  task automatic do_jump(input string tag);
    opcode = 7'd49; mem_ready = 1'b1; #1;
    chk({tag, "_fetch"}, 32'(outs), 32'(O_FREADY));
    @(negedge clk); mem_ready = 1'b0; #1;
    chk({tag, "_decode"}, 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk({tag, "_jump"}, 32'(outs), 32'(ov(0,0,1,1,0,0,1,0,0,0,0,4'd0,2'd2,0)));
    @(negedge clk); #1;
    chk({tag, "_back"}, 32'(outs), 32'(O_FWAIT));
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'(O_ZERO));
    chk("reset_count", 32'(instr_count), 32'd0);

    // Release reset: START for two edges, FETCH after the second
    @(negedge clk); rst = 1'b0; #1;
    chk("rel_start0", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("rel_start1", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("rel_fetch", 32'(outs), 32'(O_FWAIT));

    // ADD
    mem_ready = 1'b1; opcode = 7'd0; #1;
    chk("add_fetch", 32'(outs), 32'(O_FREADY));
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("add_decode", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("add_exec", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("add_wb", 32'(outs), 32'(ov(0,0,0,1,0,0,0,0,0,0,0,4'd0,2'd0,0)));
    chk("add_cnt_wb", 32'(instr_count), 32'd0);
    @(negedge clk); #1;
    chk("add_back", 32'(outs), 32'(O_FWAIT));
    chk("add_cnt", 32'(instr_count), 32'd1);

    // MUL, with the opcode disturbed during EXEC
    mem_ready = 1'b1; opcode = 7'd2; #1;
    chk("mul_fetch", 32'(outs), 32'(O_FREADY));
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("mul_decode", 32'(outs), 32'(O_ZERO));
    @(negedge clk); opcode = 7'd5; #1;
    chk("mul_exec", 32'(outs), 32'(ov(0,0,0,0,0,0,0,0,0,0,0,4'd2,2'd0,0)));
    @(negedge clk); opcode = 7'd2; #1;
    chk("mul_wb", 32'(outs), 32'(ov(0,0,0,1,0,0,0,0,0,0,0,4'd2,2'd0,0)));
    @(negedge clk); #1;
    chk("mul_cnt", 32'(instr_count), 32'd2);

    // LDW with mem_ready delayed 3 cycles in MEMRD: 8 cycles total
    mem_ready = 1'b1; opcode = 7'd17; #1;
    chk("ldw_fetch", 32'(outs), 32'(O_FREADY));
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("ldw_decode", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("ldw_memadr", 32'(outs), 32'(ov(0,0,0,0,1,0,0,0,0,0,0,4'd0,2'd0,0)));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 3); #1;
      chk("ldw_memrd", 32'(outs), 32'(ov(1,0,0,0,0,0,0,0,1,0,0,4'd0,2'd0,0)));
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("ldw_wb", 32'(outs), 32'(ov(0,0,0,1,0,1,0,0,0,0,0,4'd0,2'd0,0)));
    @(negedge clk); #1;
    chk("ldw_back", 32'(outs), 32'(O_FWAIT));
    chk("ldw_cnt", 32'(instr_count), 32'd3);

    // STB: FETCH wait, mem_ready ignored in DECODE/MEMADR, one MEMWR wait
    opcode = 7'd18; mem_ready = 1'b0; #1;
    chk("stb_fwait", 32'(outs), 32'(O_FWAIT));
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("stb_fetch", 32'(outs), 32'(O_FREADY));
    @(negedge clk); #1;
    chk("stb_decode", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("stb_memadr", 32'(outs), 32'(ov(0,0,0,0,1,0,0,0,0,0,0,4'd0,2'd0,0)));
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("stb_memwr0", 32'(outs), 32'(ov(1,0,0,0,0,0,0,0,0,1,0,4'd0,2'd0,0)));
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("stb_memwr1", 32'(outs), 32'(ov(1,0,0,0,0,0,0,0,0,1,0,4'd0,2'd0,0)));
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("stb_back", 32'(outs), 32'(O_FWAIT));
    chk("stb_cnt", 32'(instr_count), 32'd4);

    // STW interrupted by reset during the MEMWR wait
    opcode = 7'd19; mem_ready = 1'b1; #1;
    chk("stw_fetch", 32'(outs), 32'(O_FREADY));
    @(negedge clk); mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("stw_memwr", 32'(outs), 32'(ov(1,0,0,0,0,0,0,0,0,0,1,4'd0,2'd0,0)));
    @(negedge clk); #1;
    chk("stw_wait", 32'(outs), 32'(ov(1,0,0,0,0,0,0,0,0,0,1,4'd0,2'd0,0)));
    #2 rst = 1'b1; #1;
    chk("rst_mid_outs", 32'(outs), 32'(O_ZERO));
    chk("rst_mid_cnt", 32'(instr_count), 32'd0);
    @(negedge clk); #1;
    chk("rst_hold", 32'(outs), 32'(O_ZERO));
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_rel0", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("rst_rel1", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("rst_fetch", 32'(outs), 32'(O_FWAIT));

    // BEQ taken and not taken
    opcode = 7'd48; zero = 1'b1; mem_ready = 1'b1; #1;
    chk("beq1_fetch", 32'(outs), 32'(O_FREADY));
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("beq1_decode", 32'(outs), 32'(O_ZERO));
    @(negedge clk); #1;
    chk("beq1_branch", 32'(outs), 32'(ov(0,0,1,0,0,0,0,0,0,0,0,4'd1,2'd1,0)));
    @(negedge clk); #1;
    chk("beq1_cnt", 32'(instr_count), 32'd1);
    zero = 1'b0; mem_ready = 1'b1; #1;
    chk("beq0_fetch", 32'(outs), 32'(O_FREADY));
    @(negedge clk); mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    chk("beq0_branch", 32'(outs), 32'(ov(0,0,0,0,0,0,0,0,0,0,0,4'd1,2'd1,0)));
    @(negedge clk); #1;
    chk("beq0_cnt", 32'(instr_count), 32'd2);

    // Undefined opcode 0x05
    opcode = 7'h05; mem_ready = 1'b1; #1;
    chk("ill_fetch", 32'(outs), 32'(O_FREADY));
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("ill_decode", 32'(outs), 32'(ov(0,0,0,0,0,0,0,0,0,0,0,4'd0,2'd0,1)));
    @(negedge clk); #1;
    chk("ill_back", 32'(outs), 32'(O_FWAIT));
    chk("ill_cnt", 32'(instr_count), 32'd2);

    // JUMP run, then counter wrap near 0xFFFF
    for (int j = 0; j < 8; j++) begin
      do_jump("jmp");
      @(negedge clk);
    end
    chk("jmp_cnt", 32'(instr_count), 32'd10);
    force dut.count_q = 16'hFFFE;
    #1 release dut.count_q;
    #1;
    chk("wrap_preset", 32'(instr_count), 32'hFFFE);
    do_jump("wrap_a");
    chk("wrap_ffff", 32'(instr_count), 32'hFFFF);
    @(negedge clk);
    do_jump("wrap_b");
    chk("wrap_zero", 32'(instr_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
